// File: rtl/float_addsub_pipe_if.sv
// Operand/result handshake bundle for float_addsub_pipe.
// The parameters of the instance must match those of the attached pipeline.
interface float_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] v1;
  logic [W-1:0] v2;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] vres;
  logic         flag_ovf;
  logic         flag_inv;
  logic         flag_inx;

  modport master (
    output in_valid, v1, v2, op, out_ready,
    input  in_ready, out_valid, vres, flag_ovf, flag_inv, flag_inx
  );

  modport slave (
    input  in_valid, v1, v2, op, out_ready,
    output in_ready, out_valid, vres, flag_ovf, flag_inv, flag_inx
  );
endinterface

// File: rtl/float_addsub_pipe.sv
// Five-stage IEEE-style floating-point add/subtract with round-to-nearest-even,
// flush-to-zero, and a global stall driven by output back-pressure.
module float_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  float_addsub_pipe_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int unsigned XW = EXP_W + 8;  // headroom for signed exponent arithmetic
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  logic adv;
  assign adv = ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = adv;

  // Stage 1: effective sign, swap, classification
  logic               sa, sb, a_big;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               c1_spec, c1_inv;
  logic [W-1:0]       c1_val;

  assign sa     = bus.v1[W-1];
  assign sb     = bus.v2[W-1] ^ bus.op;
  assign ea     = bus.v1[W-2:MAN_W];
  assign eb     = bus.v2[W-2:MAN_W];
  assign fa     = bus.v1[MAN_W-1:0];
  assign fb     = bus.v2[MAN_W-1:0];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  assign a_big  = bus.v1[W-2:0] >= bus.v2[W-2:0];

  always_comb begin
    c1_spec = 1'b1;
    c1_inv  = 1'b0;
    c1_val  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      c1_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      c1_inv = 1'b1;
    end else if (a_inf) begin
      c1_val = bus.v1;
    end else if (b_inf) begin
      c1_val = {sb, bus.v2[W-2:0]};
    end else if (a_zero && b_zero) begin
      c1_val = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      c1_val = {sb, bus.v2[W-2:0]};
    end else if (b_zero) begin
      c1_val = bus.v1;
    end else begin
      c1_spec = 1'b0;
    end
  end

  logic s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
  logic s1_spec, s2_spec, s3_spec, s4_spec;
  logic s1_inv, s2_inv, s3_inv, s4_inv;
  logic [W-1:0] s1_val, s2_val, s3_val, s4_val;
  logic s1_sign, s2_sign, s3_sign, s4_sign;
  logic s1_sub, s2_sub;
  logic [EXP_W-1:0] s1_eb, s1_es, s2_exp, s3_exp;
  logic [MAN_W:0] s1_mb, s1_ms;
  logic [SW-1:0] s2_big, s2_al, s4_norm;
  logic [SW:0] s3_sum;
  logic signed [XW-1:0] s4_exp;
  logic s4_zero;
  logic [W-1:0] s5_vres;
  logic s5_ovf, s5_inv, s5_inx;

  // Stage 2: alignment with guard/round/sticky
  logic [EXP_W-1:0] c2_diff;
  logic [SW-1:0]    c2_ext, c2_shf, c2_mask, c2_al;
  logic             c2_lost;

  always_comb begin
    c2_diff = s1_eb - s1_es;
    c2_ext  = {s1_ms, 3'b000};
    c2_shf  = c2_ext >> c2_diff;
    c2_mask = ~({SW{1'b1}} << c2_diff);
    c2_lost = |(c2_ext & c2_mask);
    if (32'(c2_diff) >= MAN_W + 3) c2_al = {{(SW-1){1'b0}}, |s1_ms};
    else                           c2_al = {c2_shf[SW-1:1], c2_shf[0] | c2_lost};
  end

  // Stage 3: magnitude add/subtract; big >= small so subtraction never wraps
  logic [SW:0] c3_sum;
  assign c3_sum = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_al}) : ({1'b0, s2_big} + {1'b0, s2_al});

  // Stage 4: normalisation
  logic [6:0]           c4_lz;
  logic                 c4_found;
  logic [SW-1:0]        c4_norm;
  logic signed [XW-1:0] c4_exp;

  always_comb begin
    c4_lz    = '0;
    c4_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!c4_found) begin
        if (s3_sum[i]) c4_found = 1'b1;
        else           c4_lz    = c4_lz + 7'd1;
      end
    end
    c4_exp = $signed(XW'(s3_exp));
    if (s3_sum[SW]) begin
      c4_norm = {s3_sum[SW:2], s3_sum[1] | s3_sum[0]};
      c4_exp  = c4_exp + $signed(XW'(1));
    end else begin
      c4_norm = s3_sum[SW-1:0] << c4_lz;
      c4_exp  = c4_exp - $signed(XW'(c4_lz));
    end
  end

  // Stage 5: round to nearest even and range checks
  logic                 c5_up, c5_inx, c5_ovf;
  logic [MAN_W+1:0]     c5_man;
  logic [MAN_W-1:0]     c5_frac;
  logic signed [XW-1:0] c5_exp;
  logic [W-1:0]         c5_res;

  always_comb begin
    c5_up   = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
    c5_man  = {1'b0, s4_norm[SW-1:3]} + (MAN_W+2)'(c5_up);
    c5_exp  = c5_man[MAN_W+1] ? (s4_exp + $signed(XW'(1))) : s4_exp;
    c5_frac = c5_man[MAN_W+1] ? c5_man[MAN_W:1] : c5_man[MAN_W-1:0];
    c5_inx  = |s4_norm[2:0];
    c5_ovf  = 1'b0;
    c5_res  = {s4_sign, c5_exp[EXP_W-1:0], c5_frac};
    if (s4_zero) begin
      c5_res = '0;
      c5_inx = 1'b0;
    end else if (s4_exp <= $signed(XW'(0))) begin
      c5_res = {s4_sign, {(W-1){1'b0}}};
      c5_inx = 1'b1;
    end else if (c5_exp >= EMAX) begin
      c5_res = {s4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c5_ovf = 1'b1;
      c5_inx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s5_valid <= 1'b0;
      s5_vres  <= '0;
      s5_ovf   <= 1'b0;
      s5_inv   <= 1'b0;
      s5_inx   <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s4_valid <= s3_valid;
      s5_valid <= s4_valid;
      s5_vres  <= s4_spec ? s4_val : c5_res;
      s5_ovf   <= ~s4_spec & c5_ovf;
      s5_inv   <= s4_spec & s4_inv;
      s5_inx   <= ~s4_spec & c5_inx;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_spec <= c1_spec;
      s1_inv  <= c1_inv;
      s1_val  <= c1_val;
      s1_sign <= a_big ? sa : sb;
      s1_sub  <= sa ^ sb;
      s1_eb   <= a_big ? ea : eb;
      s1_es   <= a_big ? eb : ea;
      s1_mb   <= a_big ? {1'b1, fa} : {1'b1, fb};
      s1_ms   <= a_big ? {1'b1, fb} : {1'b1, fa};
      s2_spec <= s1_spec;
      s2_inv  <= s1_inv;
      s2_val  <= s1_val;
      s2_sign <= s1_sign;
      s2_sub  <= s1_sub;
      s2_exp  <= s1_eb;
      s2_big  <= {s1_mb, 3'b000};
      s2_al   <= c2_al;
      s3_spec <= s2_spec;
      s3_inv  <= s2_inv;
      s3_val  <= s2_val;
      s3_sign <= s2_sign;
      s3_exp  <= s2_exp;
      s3_sum  <= c3_sum;
      s4_spec <= s3_spec;
      s4_inv  <= s3_inv;
      s4_val  <= s3_val;
      s4_sign <= s3_sign;
      s4_exp  <= c4_exp;
      s4_norm <= c4_norm;
      s4_zero <= ~(|s3_sum);
    end
  end

  assign bus.out_valid = s5_valid;
  assign bus.vres      = s5_vres;
  assign bus.flag_ovf  = s5_ovf;
  assign bus.flag_inv  = s5_inv;
  assign bus.flag_inx  = s5_inx;
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe with single-precision vectors.
module tb_float_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  float_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  float_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] b2b_in  [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] b2b_out [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic [31:0] r, input logic [2:0] f);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.v1 = a;
    bus.v2 = b;
    bus.op = o;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.vres, r);
    check({tag, "_flags"}, {29'd0, bus.flag_ovf, bus.flag_inv, bus.flag_inx}, {29'd0, f});
  endtask

  int tx, rx, stall_cnt, seen;
  bit started, taken;

  initial begin
    bus.in_valid  = 1'b0;
    bus.v1        = '0;
    bus.v2        = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_vres", bus.vres, 32'd0);
    check("rst_flags", {29'd0, bus.flag_ovf, bus.flag_inv, bus.flag_inx}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // flags are {ovf, inv, inx}
    run_one("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    run_one("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
    run_one("tie_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    run_one("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101);
    run_one("inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b010);
    run_one("cancel",       32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 3'b000);
    run_one("inf_p_one",    32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    run_one("zero_p_y",     32'h00000000, 32'hC0A00000, 1'b0, 32'hC0A00000, 3'b000);
    run_one("pz_p_nz",      32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    run_one("nz_p_nz",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    run_one("one_m_half",   32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 3'b000);
    run_one("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b010);
    run_one("two_p_m3",     32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 3'b000);
    run_one("underflow",    32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001);

    // Back-to-back stream with a 3-cycle output stall
    tx = 0; rx = 0; stall_cnt = 0; started = 0; taken = 0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      @(negedge clk);
      if (taken) tx++;
      bus.in_valid = (tx < 8);
      bus.v1 = b2b_in[(tx < 8) ? tx : 0];
      bus.v2 = 32'h3F800000;
      bus.op = 1'b0;
      if (!started && bus.out_valid) begin
        started   = 1;
        stall_cnt = 3;
      end
      bus.out_ready = (stall_cnt == 0);
      #1;
      taken = bus.in_valid && bus.in_ready;
      if (stall_cnt > 0) begin
        check("b2b_stall_ready", 32'(bus.in_ready), 32'd0);
        stall_cnt--;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("b2b_res", bus.vres, b2b_out[rx]);
        rx++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("b2b_count", rx, 32'd8);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("b2b_extra", seen, 32'd0);

    // Reset with three sets in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.v1 = 32'h3F800000;
    bus.v2 = 32'h3F800000;
    @(negedge clk);
    bus.v1 = 32'h40000000;
    @(negedge clk);
    bus.v1 = 32'h40400000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_vres", bus.vres, 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_discard", seen, 32'd0);
    run_one("post_rst", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
